// File: rtl/bram_stream_writer.sv
// bram_stream_writer: writes a valid/ready word stream into BRAM port A as a two-half ping-pong buffer.
// Latency: a word accepted in cycle N is on port A in cycle N+1; half_done pulses with the last write of a half.
// Backpressure: s_ready is a registered state decode; low when no half is free (unless DROP_ON_FULL) and,
//   with BRAM_WR_HEADER_EN defined, low for the one header-write cycle at the start of each half.
module bram_stream_writer #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 16384,
    parameter int DROP_ON_FULL = 0,
    localparam int HALF_WORDS  = DEPTH / 2,
    localparam int IDX_W       = $clog2(HALF_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    input  logic                  half_ack,
    input  logic                  ack_id,
    output logic                  bram_en,
    output logic [3:0]            bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    output logic                  half_done,
    output logic                  half_id,
    output logic [1:0]            half_full,
    output logic [IDX_W-1:0]      wr_idx,
    output logic [15:0]           drop_count
);

    typedef enum logic [1:0] {IDLE, WRITE, WAIT_FREE, HDR} state_t;

    localparam logic DROP = (DROP_ON_FULL != 0);

    // FRESH is where the FSM goes when it starts a half at idx 0.
`ifdef BRAM_WR_HEADER_EN
    localparam state_t FRESH     = HDR;
    localparam logic   FRESH_RDY = 1'b0;
    logic [15:0] seq;
`else
    localparam state_t FRESH     = WRITE;
    localparam logic   FRESH_RDY = 1'b1;
`endif

    state_t           state;
    logic             half;
    logic [IDX_W-1:0] idx;
    logic [1:0]       full_q;
    logic [1:0]       full_nxt;
    logic             accept;
    logic             last;
    logic             wr_acc;
    logic             drop_acc;
    logic             end_half;
    logic             ack_hit;

    assign accept    = s_valid & s_ready;
    assign last      = (idx == IDX_W'(HALF_WORDS - 1));
    assign wr_acc    = accept && (state == WRITE);
    assign drop_acc  = accept && (state == WAIT_FREE);
    assign end_half  = wr_acc && last;
    assign ack_hit   = half_ack && full_q[ack_id];
    assign half_full = full_q;
    assign wr_idx    = idx;

    // Ownership flags after this cycle: ack clears first so a simultaneous fill of the same half wins.
    always_comb begin
        full_nxt = full_q;
        if (ack_hit) begin
            full_nxt[ack_id] = 1'b0;
        end
        if (end_half) begin
            full_nxt[half] = 1'b1;
        end
    end

    // Control FSM; s_ready is registered together with the state it decodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            s_ready <= 1'b0;
        end else if (clear) begin
            state   <= IDLE;
            s_ready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        if (full_nxt[half]) begin
                            state   <= WAIT_FREE;
                            s_ready <= DROP;
                        end else if (idx == '0) begin
                            state   <= FRESH;
                            s_ready <= FRESH_RDY;
                        end else begin
                            state   <= WRITE;
                            s_ready <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (!enable) begin
                        state   <= IDLE;
                        s_ready <= 1'b0;
                    end else if (end_half) begin
                        if (full_nxt[!half]) begin
                            state   <= WAIT_FREE;
                            s_ready <= DROP;
                        end else begin
                            state   <= FRESH;
                            s_ready <= FRESH_RDY;
                        end
                    end
                end
                WAIT_FREE: begin
                    if (!enable) begin
                        state   <= IDLE;
                        s_ready <= 1'b0;
                    end else if (!full_nxt[half]) begin
                        state   <= FRESH;
                        s_ready <= FRESH_RDY;
                    end
                end
                HDR: begin
                    state   <= enable ? WRITE : IDLE;
                    s_ready <= enable;
                end
                default: begin
                    state   <= IDLE;
                    s_ready <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: port A write register, half pointer, ownership flags and drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bram_en    <= 1'b0;
            bram_we    <= 4'h0;
            bram_addr  <= '0;
            bram_din   <= '0;
            half_done  <= 1'b0;
            half_id    <= 1'b0;
            half       <= 1'b0;
            idx        <= '0;
            full_q     <= 2'b00;
            drop_count <= 16'h0000;
`ifdef BRAM_WR_HEADER_EN
            seq        <= 16'h0000;
`endif
        end else begin
            bram_en   <= 1'b0;
            bram_we   <= 4'h0;
            half_done <= 1'b0;
            if (clear) begin
                // A word accepted in the clear cycle is discarded; the write already on the port is untouched.
                half       <= 1'b0;
                idx        <= '0;
                full_q     <= 2'b00;
                drop_count <= 16'h0000;
`ifdef BRAM_WR_HEADER_EN
                seq        <= 16'h0000;
`endif
            end else begin
                full_q <= full_nxt;
                if (wr_acc) begin
                    bram_en   <= 1'b1;
                    bram_we   <= 4'hF;
                    bram_addr <= ADDR_WIDTH'({half, idx, 2'b00});
                    bram_din  <= s_data;
                    if (last) begin
                        half      <= !half;
                        idx       <= '0;
                        half_done <= 1'b1;
                        half_id   <= half;
`ifdef BRAM_WR_HEADER_EN
                        seq       <= seq + 16'd1;
`endif
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
`ifdef BRAM_WR_HEADER_EN
                if (state == HDR) begin
                    bram_en   <= 1'b1;
                    bram_we   <= 4'hF;
                    bram_addr <= ADDR_WIDTH'({half, idx, 2'b00});
                    bram_din  <= DATA_WIDTH'({16'hA5C3, seq});
                    idx       <= IDX_W'(1);
                end
`endif
                if (drop_acc && (drop_count != 16'hFFFF)) begin
                    drop_count <= drop_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bram_stream_writer.sv
module tb_bram_stream_writer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DUT a: stalling variant; DUT b: dropping variant. Both DEPTH=8 (4 words per half).
    logic        a_en = 0, a_clr = 0, a_v = 0, a_ack = 0, a_aid = 0;
    logic [31:0] a_d = '0;
    logic        a_rdy, a_ben, a_done, a_hid;
    logic [3:0]  a_we;
    logic [15:0] a_addr, a_drop;
    logic [31:0] a_din;
    logic [1:0]  a_full, a_idx;

    logic        b_en = 0, b_clr = 0, b_v = 0, b_ack = 0, b_aid = 0;
    logic [31:0] b_d = '0;
    logic        b_rdy, b_ben, b_done, b_hid;
    logic [3:0]  b_we;
    logic [15:0] b_addr, b_drop;
    logic [31:0] b_din;
    logic [1:0]  b_full, b_idx;

    bram_stream_writer #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(8), .DROP_ON_FULL(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(a_en), .clear(a_clr), .s_valid(a_v), .s_data(a_d),
        .s_ready(a_rdy), .half_ack(a_ack), .ack_id(a_aid), .bram_en(a_ben), .bram_we(a_we),
        .bram_addr(a_addr), .bram_din(a_din), .half_done(a_done), .half_id(a_hid),
        .half_full(a_full), .wr_idx(a_idx), .drop_count(a_drop));

    bram_stream_writer #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(8), .DROP_ON_FULL(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(b_en), .clear(b_clr), .s_valid(b_v), .s_data(b_d),
        .s_ready(b_rdy), .half_ack(b_ack), .ack_id(b_aid), .bram_en(b_ben), .bram_we(b_we),
        .bram_addr(b_addr), .bram_din(b_din), .half_done(b_done), .half_id(b_hid),
        .half_full(b_full), .wr_idx(b_idx), .drop_count(b_drop));

    // Shadow of BRAM contents written by dut_a, indexed by word address.
    logic [31:0] mem [8];
    int          a_writes = 0;
    always @(posedge clk) begin
        if (a_ben && a_we == 4'hF) begin
            mem[a_addr[4:2]] <= a_din;
            a_writes <= a_writes + 1;
        end
    end

    typedef struct {
        logic        en, clr, v;
        logic [31:0] d;
        logic        ack, aid;
        logic        rdy, ben, cb;
        logic [15:0] addr;
        logic [31:0] din;
        logic        done, hid;
        logic [1:0]  full, idx;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic en, clr, v, input logic [31:0] d, input logic ack, aid,
                                input logic rdy, ben, cb, input logic [15:0] addr, input logic [31:0] din,
                                input logic done, hid, input logic [1:0] full, idx);
        vec_t r;
        r.en = en; r.clr = clr; r.v = v; r.d = d; r.ack = ack; r.aid = aid;
        r.rdy = rdy; r.ben = ben; r.cb = cb; r.addr = addr; r.din = din;
        r.done = done; r.hid = hid; r.full = full; r.idx = idx;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state, sampled while reset is held.
        #12;
        chk("rst s_ready", a_rdy, 0);
        chk("rst bram_en", a_ben, 0);
        chk("rst bram_we", a_we, 0);
        chk("rst half_done", a_done, 0);
        chk("rst half_full", a_full, 0);
        chk("rst wr_idx", a_idx, 0);
        chk("rst drop_count", b_drop, 0);
        #11 rst_n = 1'b1;
        tick();

`ifdef BRAM_WR_HEADER_EN
        begin
            int k;
            int cyc;
            logic acc;
            logic [31:0] exp_mem [8];
            exp_mem[0] = 32'hA5C30000; exp_mem[1] = 1; exp_mem[2] = 2; exp_mem[3] = 3;
            exp_mem[4] = 32'hA5C30001; exp_mem[5] = 4; exp_mem[6] = 5; exp_mem[7] = 6;
            k = 1;
            cyc = 0;
            a_en = 1;
            while (k <= 6 && cyc < 60) begin
                a_v = 1;
                a_d = k;
                acc = a_rdy;
                tick();
                if (acc) k++;
                cyc++;
            end
            a_v = 0;
            chk("hdr words accepted before timeout", k, 7);
            tick();
            tick();
            for (int i = 0; i < 8; i++) chk($sformatf("hdr mem[%0d]", i), mem[i], exp_mem[i]);
            chk("hdr write count", a_writes, 8);
            chk("hdr half_full", a_full, 2'b11);
        end
`else
        // Columns: en clr v d ack aid | rdy ben check_bram addr din done hid full idx
        vt.push_back(mk(1,0,0, 0,0,0, 1,0,1,16'h00, 0,0,0,2'b00,0));
        vt.push_back(mk(1,0,1, 1,0,0, 1,1,1,16'h00, 1,0,0,2'b00,1));
        vt.push_back(mk(1,0,1, 2,0,0, 1,1,1,16'h04, 2,0,0,2'b00,2));
        vt.push_back(mk(1,0,1, 3,0,0, 1,1,1,16'h08, 3,0,0,2'b00,3));
        vt.push_back(mk(1,0,1, 4,0,0, 1,1,1,16'h0C, 4,1,0,2'b01,0));
        vt.push_back(mk(1,0,1, 5,0,0, 1,1,1,16'h10, 5,0,0,2'b01,1));
        vt.push_back(mk(1,0,1, 6,0,0, 1,1,1,16'h14, 6,0,0,2'b01,2));
        vt.push_back(mk(1,0,1, 7,0,0, 1,1,1,16'h18, 7,0,0,2'b01,3));
        vt.push_back(mk(1,0,1, 8,0,0, 0,1,1,16'h1C, 8,1,1,2'b11,0));
        vt.push_back(mk(1,0,1, 9,0,0, 0,0,1,16'h00, 0,0,0,2'b11,0));
        vt.push_back(mk(1,0,1, 9,1,0, 1,0,1,16'h00, 0,0,0,2'b10,0));
        vt.push_back(mk(1,0,1, 9,0,0, 1,1,1,16'h00, 9,0,0,2'b10,1));
        vt.push_back(mk(1,0,1,10,0,0, 1,1,1,16'h04,10,0,0,2'b10,2));
        vt.push_back(mk(0,0,0, 0,0,0, 0,0,1,16'h00, 0,0,0,2'b10,2));
        for (int i = 0; i < 4; i++)
            vt.push_back(mk(0,0,1,99,0,0, 0,0,1,16'h00, 0,0,0,2'b10,2));
        vt.push_back(mk(1,0,1,99,0,0, 1,0,1,16'h00, 0,0,0,2'b10,2));
        vt.push_back(mk(1,0,1,11,0,0, 1,1,1,16'h08,11,0,0,2'b10,3));
        vt.push_back(mk(1,1,1,12,0,0, 0,0,0,16'h00, 0,0,0,2'b00,0));
        vt.push_back(mk(1,0,0, 0,0,0, 1,0,1,16'h00, 0,0,0,2'b00,0));
        vt.push_back(mk(1,0,1,13,0,0, 1,1,1,16'h00,13,0,0,2'b00,1));
        vt.push_back(mk(1,0,1,14,0,0, 1,1,1,16'h04,14,0,0,2'b00,2));
        vt.push_back(mk(1,0,1,15,0,0, 1,1,1,16'h08,15,0,0,2'b00,3));
        vt.push_back(mk(1,0,1,16,1,0, 1,1,1,16'h0C,16,1,0,2'b01,0));
        vt.push_back(mk(1,0,0, 0,1,1, 1,0,1,16'h00, 0,0,0,2'b01,0));

        for (int i = 0; i < vt.size(); i++) begin
            a_en = vt[i].en; a_clr = vt[i].clr; a_v = vt[i].v; a_d = vt[i].d;
            a_ack = vt[i].ack; a_aid = vt[i].aid;
            tick();
            chk($sformatf("v%0d s_ready", i), a_rdy, vt[i].rdy);
            if (vt[i].cb) begin
                chk($sformatf("v%0d bram_en", i), a_ben, vt[i].ben);
                chk($sformatf("v%0d bram_we", i), a_we, vt[i].ben ? 4'hF : 4'h0);
                if (vt[i].ben) begin
                    chk($sformatf("v%0d bram_addr", i), a_addr, vt[i].addr);
                    chk($sformatf("v%0d bram_din", i), a_din, vt[i].din);
                end
            end
            chk($sformatf("v%0d half_done", i), a_done, vt[i].done);
            if (vt[i].done) chk($sformatf("v%0d half_id", i), a_hid, vt[i].hid);
            chk($sformatf("v%0d half_full", i), a_full, vt[i].full);
            chk($sformatf("v%0d wr_idx", i), a_idx, vt[i].idx);
            chk($sformatf("v%0d drop_count", i), a_drop, 0);
        end
        a_ack = 0; a_v = 0;

        // Drop mode: fill both halves, then offered words are discarded and counted.
        b_en = 1;
        tick();
        for (int k = 1; k <= 8; k++) begin
            b_v = 1; b_d = k;
            tick();
        end
        chk("drop both full", b_full, 2'b11);
        chk("drop last half_id", b_hid, 1);
        chk("drop s_ready when full", b_rdy, 1);
        for (int j = 0; j < 3; j++) begin
            b_v = 1; b_d = 100 + j;
            tick();
            chk($sformatf("drop w%0d bram_en", j), b_ben, 0);
            chk($sformatf("drop w%0d s_ready", j), b_rdy, 1);
        end
        b_v = 0;
        chk("drop_count after 3", b_drop, 3);
        chk("drop wr_idx held", b_idx, 0);
        b_ack = 1; b_aid = 0;
        tick();
        b_ack = 0;
        chk("drop release full", b_full, 2'b10);
        b_v = 1; b_d = 77;
        tick();
        b_v = 0;
        chk("drop resume bram_en", b_ben, 1);
        chk("drop resume addr", b_addr, 16'h0);
        chk("drop resume din", b_din, 77);
        chk("drop_count kept", b_drop, 3);
        b_clr = 1;
        tick();
        b_clr = 0;
        chk("clear drop_count", b_drop, 0);
        chk("clear half_full", b_full, 0);
        chk("clear wr_idx", b_idx, 0);
`endif

        // Asynchronous reset takes effect without waiting for a clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("async rst half_full", a_full, 0);
        chk("async rst s_ready", a_rdy, 0);
        chk("async rst wr_idx", a_idx, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_stream_writer.md
Name: bram_stream_writer

Overview:
- Upstream stage of the simple dual-port BRAM. Accepts a valid/ready stream of 32-bit sample words from the Intan capture logic and drives BRAM port A.
- Treats the BRAM as a ping-pong buffer of two halves. Signals software when a half is full and waits for software to release it.
- Software reads full halves through the AXI BRAM controller on port B.

Parameters:
- ADDR_WIDTH, 16: port A byte-address width.
- DATA_WIDTH, 32: word width. Only 32 is supported.
- DEPTH, 16384: total words; even, power of two. HALF_WORDS = DEPTH/2.
- DROP_ON_FULL, 0: 0 = stall the stream when no half is free; 1 = keep s_ready high and discard words.

Ports:
- clk  in  1  single clock, shared with BRAM port A.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; 1 = accept the stream.
- clear  in  1  one-cycle pulse; resets pointer, ownership flags and counters.
- s_valid  in  1  stream word valid.
- s_data  in  32  stream word.
- s_ready  out  1  stream ready.
- half_ack  in  1  one-cycle pulse; software releases a half.
- ack_id  in  1  index of the half being released.
- bram_en  out  1  port A enable.
- bram_we  out  4  port A byte write enables; 4'hF or 0.
- bram_addr  out  ADDR_WIDTH  port A byte address.
- bram_din  out  32  port A write data.
- half_done  out  1  one-cycle pulse when a half is filled.
- half_id  out  1  index of the half just filled; valid with half_done.
- half_full  out  2  per-half software-owned flags.
- wr_idx  out  log2(HALF_WORDS)  current word index within the active half.
- drop_count  out  16  words discarded; saturates at 16'hFFFF.

Behaviour:
- Reset: all outputs 0, active half = 0, wr_idx = 0, state IDLE. Reset values are restored immediately on the asynchronous reset edge.
- States:
  - IDLE: s_ready = 0. Goes to WRITE when enable = 1.
  - WRITE: s_ready = 1. Goes to IDLE when enable = 0. Goes to WAIT_FREE when a half completes and the other half is full.
  - WAIT_FREE: s_ready = DROP_ON_FULL. Goes to WRITE when the target half is released. Goes to IDLE when enable = 0.
- Handshake: a word is accepted when s_valid & s_ready. s_ready depends only on state (registered), never on s_valid.
- Write latency: a word accepted in cycle N appears in cycle N+1 as bram_en = 1, bram_we = 4'hF, bram_din = word, bram_addr = ((half*HALF_WORDS) + idx) << 2, truncated to ADDR_WIDTH. In all other cycles bram_en = 0 and bram_we = 0.
- End of half: accepting the word at idx = HALF_WORDS-1 does the following in the next cycle:
  - sets half_full[half];
  - pulses half_done with half_id = half;
  - toggles the active half;
  - sets wr_idx to 0.
  - If the new active half is already full, the state becomes WAIT_FREE.
- DROP_ON_FULL = 1 in WAIT_FREE: accepted words are not written; drop_count increments by 1 (saturating).
- half_ack clears half_full[ack_id]. An ack for a half that is not full is ignored.
  - If an ack and an end-of-half set hit the same half in the same cycle, the set wins.
  - An ack arriving in WAIT_FREE resumes WRITE on the next cycle. The first post-stall write goes to idx 0 of the released half.
- enable drop mid-half: stop accepting at the next cycle; wr_idx and the active half are retained. A write already in flight completes.
- clear: takes priority over everything else. In the next cycle it sets active half = 0, wr_idx = 0, half_full = 0, drop_count = 0, state = IDLE (re-enters WRITE if enable = 1).
  - A pending half_done pulse is suppressed.
  - A write already in flight in the clear cycle still completes.
- Only one outstanding BRAM write at a time; there is no read-back on port A.

Optional Feature:
- Macro: BRAM_WR_HEADER_EN.
- When defined: on entering idx 0 of a half (including after reset or clear), the block spends one cycle writing a header word before accepting stream data.
  - s_ready = 0 during that cycle.
  - Header word = {16'hA5C3, seq[15:0]}. seq is a 16-bit half counter, incremented per completed half, wrapping, cleared by clear and by reset.
  - Stream data starts at idx 1, so each half holds HALF_WORDS-1 samples.
- When undefined: no header; stream data starts at idx 0; the seq logic is absent.

Test Plan:
- DEPTH=8, macro undefined, enable=1, stream words 1..4 back-to-back → four port A writes:
  - byte addresses 0x0, 0x4, 0x8, 0xC with data 1..4, each one cycle after acceptance;
  - half_done pulses once with half_id=0; half_full=2'b01.
- Continue with words 5..8 and no ack → writes at 0x10..0x1C; half_full=2'b11; state WAIT_FREE; s_ready=0. Then half_ack with ack_id=0 → s_ready=1 next cycle; word 9 is written at 0x0.
- DROP_ON_FULL=1, both halves full, 3 words offered → s_ready stays 1, no BRAM writes, drop_count=3.
- Deassert enable after word 2, reassert 5 cycles later, send word 3 → word 3 is written at 0x8; no half_done pulse.
- Assert clear in the same cycle as the last word of a half → no half_done pulse; next word is written at 0x0; half_full=0; drop_count=0.
- BRAM_WR_HEADER_EN defined, DEPTH=8, 6 words → 0x0=A5C30000, 0x4..0xC=words 1..3, 0x10=A5C30001, 0x14..0x1C=words 4..6.
